// File: rtl/fmul_issue_ctrl.sv
// Operand issue / result capture controller for the pipelined fp16 multiplier.
// Buffers operand pairs, holds each on the multiplier across APPLY/SAMPLE, repacks the result.
module fmul_issue_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:1] in_Operand_1,
  input  logic [16:1] in_Operand_2,
  output logic        mul_Sign_1,
  output logic        mul_Sign_2,
  output logic [4:0]  mul_Exponent_1,
  output logic [4:0]  mul_Exponent_2,
  output logic [9:0]  mul_Mantissa_1,
  output logic [9:0]  mul_Mantissa_2,
  input  logic        mul_out_Sign,
  input  logic [5:1]  mul_out_Exponent,
  input  logic [10:1] mul_out_Mantissa,
  input  logic        mul_Overflow,
  input  logic        mul_Underflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_Result,
  output logic        out_Overflow,
  output logic        out_Underflow
);

  localparam int unsigned OW = 16;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE} state_t;

  state_t            state_q, state_d;
  logic [2*OW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [OW:1]       op1_q, op2_q;
  logic              push, pop, capture;

  assign push = in_valid & in_ready;
  assign count_d = count_q + CW'(push) - CW'(pop);

  // Next-state: pop on leaving IDLE or on a back-to-back SAMPLE capture
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = APPLY;
        end
      end
      APPLY: state_d = SAMPLE;
      SAMPLE: begin
        if (!out_valid || out_ready) begin
          capture = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = APPLY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready      <= 1'b1;
      op1_q         <= '0;
      op2_q         <= '0;
      out_valid     <= 1'b0;
      out_Result    <= '0;
      out_Overflow  <= 1'b0;
      out_Underflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      in_ready <= (count_d < CW'(FIFO_DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        op1_q    <= fifo_mem[rd_ptr_q][2*OW-1:OW];
        op2_q    <= fifo_mem[rd_ptr_q][OW-1:0];
      end
      if (capture) begin
        out_valid     <= 1'b1;
        out_Result    <= {mul_out_Sign, mul_out_Exponent, mul_out_Mantissa};
        out_Overflow  <= mul_Overflow;
        out_Underflow <= mul_Underflow;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Storage array needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {in_Operand_1, in_Operand_2};
  end

  assign mul_Sign_1     = op1_q[16];
  assign mul_Exponent_1 = op1_q[15:11];
  assign mul_Mantissa_1 = op1_q[10:1];
  assign mul_Sign_2     = op2_q[16];
  assign mul_Exponent_2 = op2_q[15:11];
  assign mul_Mantissa_2 = op2_q[10:1];

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Scoreboard bench for fmul_issue_ctrl with a behavioural fp16 multiplier stub
// whose mantissa path is registered, so early sampling yields stale data.
module tb_fmul_issue_ctrl;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] op_a, op_b;
  logic        mul_Sign_1, mul_Sign_2;
  logic [4:0]  mul_Exponent_1, mul_Exponent_2;
  logic [9:0]  mul_Mantissa_1, mul_Mantissa_2;
  logic        mul_out_Sign;
  logic [4:0]  mul_out_Exponent;
  logic [9:0]  mul_out_Mantissa;
  logic        mul_Overflow, mul_Underflow;
  logic        out_valid, out_ready;
  logic [15:0] out_Result;
  logic        out_Overflow, out_Underflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  logic [17:0] last_res = '0;
  logic [17:0] exp_q[$];
  logic        rand_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fmul_issue_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_Operand_1(op_a), .in_Operand_2(op_b),
    .mul_Sign_1(mul_Sign_1), .mul_Sign_2(mul_Sign_2),
    .mul_Exponent_1(mul_Exponent_1), .mul_Exponent_2(mul_Exponent_2),
    .mul_Mantissa_1(mul_Mantissa_1), .mul_Mantissa_2(mul_Mantissa_2),
    .mul_out_Sign(mul_out_Sign), .mul_out_Exponent(mul_out_Exponent),
    .mul_out_Mantissa(mul_out_Mantissa),
    .mul_Overflow(mul_Overflow), .mul_Underflow(mul_Underflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_Result(out_Result), .out_Overflow(out_Overflow), .out_Underflow(out_Underflow)
  );

  // fp16 product with truncation; returns {overflow, underflow, result}
  function automatic logic [17:0] fmul_ref(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int e;
    logic [21:0] p;
    logic [9:0] m;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {2'b00, s, 15'd0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin m = p[20:11]; e++; end
    else m = p[19:10];
    if (e >= 31) return {2'b10, s, 5'h1f, 10'd0};
    if (e <= 0) return {2'b01, s, 15'd0};
    return {2'b00, s, 5'(e), m};
  endfunction

  // Multiplier stub: sign/exponent/flags combinational, mantissa registered
  logic [17:0] stub_f;
  logic [9:0]  mant_q;
  assign stub_f = fmul_ref({mul_Sign_1, mul_Exponent_1, mul_Mantissa_1},
                           {mul_Sign_2, mul_Exponent_2, mul_Mantissa_2});
  assign mul_out_Sign     = stub_f[15];
  assign mul_out_Exponent = stub_f[14:10];
  assign mul_Overflow     = stub_f[17];
  assign mul_Underflow    = stub_f[16];
  assign mul_out_Mantissa = mant_q;
  always_ff @(posedge clk) begin
    if (reset) mant_q <= '0;
    else mant_q <= stub_f[9:0];
  end

  // Scoreboard: record accepted pairs, compare each handed-off result in order
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        prev_cyc = last_cyc;
        last_cyc = cyc;
        last_res = {out_Overflow, out_Underflow, out_Result};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got=%h", last_res);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          if (last_res !== e) begin
            errors++;
            $display("FAIL out_result got=%h req=%h", last_res, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(fmul_ref(op_a, op_b));
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h req=%h", name, got, req);
    end
  endtask

  // Present a pair and hold it until accepted; leaves in_valid high
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_timeout", 32'(k < 1000), 32'd1);
  endtask

  initial begin
    logic [15:0] pa[7], pb[7];
    int idx, n0;
    logic acc;
    reset = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; out_ready = 1'b1; rand_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", {13'd0, out_Overflow, out_Underflow, out_Result}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mul", {mul_Sign_1, mul_Exponent_1, mul_Mantissa_1, mul_Sign_2, mul_Exponent_2, mul_Mantissa_2}, 32'd0);

    // Single op latency
    in_valid = 1'b1; op_a = 16'h3C00; op_b = 16'h3C00;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_result", {13'd0, out_Overflow, out_Underflow, out_Result}, 32'h3C00);
    wait_drain();

    // Back-to-back
    send(16'h4000, 16'h4200);
    send(16'h3C00, 16'h4500);
    in_valid = 1'b0;
    wait_drain();
    chk("b2b_last", 32'(last_res), 32'h4500);
    chk("b2b_spacing", 32'(last_cyc - prev_cyc), 32'd2);

    // Zero operand and overflow
    send(16'h0000, 16'h4500); in_valid = 1'b0; wait_drain();
    chk("zero_res", 32'(last_res), 32'h0);
    send(16'h7800, 16'h7800); in_valid = 1'b0; wait_drain();
    chk("ovf_flag", 32'(last_res[17:16]), 32'b10);

    // Backpressure: 7 offered, 6 fit
    for (int i = 0; i < 7; i++) begin pa[i] = 16'($urandom); pb[i] = 16'($urandom); end
    out_ready = 1'b0; idx = 0; n0 = n_out;
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1; op_a = pa[idx]; op_b = pb[idx];
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd6);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_held_ops", {mul_Sign_1, mul_Exponent_1, mul_Mantissa_1}, 32'(pa[1]));
    out_ready = 1'b1;
    send(pa[6], pb[6]);
    in_valid = 1'b0;
    wait_drain();
    chk("bp_count", 32'(n_out - n0), 32'd7);
    chk("bp_ready_back", 32'(in_ready), 32'd1);

    // Reset mid-burst while stalled in SAMPLE with 3 queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom));
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1; n0 = n_out;
    repeat (20) @(posedge clk);
    #1 chk("mrst_no_stale", 32'(n_out - n0), 32'd0);

    // Randomized traffic with random backpressure
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send(16'($urandom), 16'($urandom));
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        for (int k = 0; k < 5000 && !rand_done; k++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("rand_count", 32'(n_out - n0), 32'd150);
    chk("end_in_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmul_issue_ctrl.md
# fmul_issue_ctrl

Operand issue and result capture controller for the pipelined half-precision multiplier. Accepts packed operand pairs over a valid/ready handshake and buffers them in a small FIFO. Each pair is presented to the multiplier long enough for its combinational and registered paths to agree, and the multiplier's result and flags are repacked into a single-entry output register with its own valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, operand-pair FIFO entries; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; also driven to the multiplier's reset
- in_valid  input  1  upstream operand pair valid
- in_ready  output  1  FIFO can accept; high iff FIFO count < FIFO_DEPTH
- in_Operand_1, in_Operand_2  input  16 each  [16:1] packed: [16] sign, [15:11] exponent, [10:1] mantissa
- mul_Sign_1, mul_Sign_2  output  1 each  to multiplier sign inputs
- mul_Exponent_1, mul_Exponent_2  output  5 each  to multiplier exponent inputs
- mul_Mantissa_1, mul_Mantissa_2  output  10 each  to multiplier mantissa inputs
- mul_out_Sign, mul_out_Exponent[5:1], mul_out_Mantissa[10:1]  input  from multiplier
- mul_Overflow, mul_Underflow  input  1 each  multiplier exponent flags
- out_valid  output  1  result register full
- out_ready  input  1  downstream accepts result
- out_Result  output  16  packed {sign, exponent, mantissa}
- out_Overflow, out_Underflow  output  1 each  flags captured with out_Result

## Operation
- FIFO: push when in_valid & in_ready; no write-through bypass; push while full is impossible (in_ready low). Entries pop strictly in order.
- Operand registers (sign, exponent, mantissa ×2) drive the mul_* outputs directly; loaded only on pop; hold value otherwise, including in IDLE.
- FSM states: IDLE, APPLY, SAMPLE.
  - IDLE: if count > 0, pop into operand registers and go to APPLY; otherwise stay.
  - APPLY: unconditionally go to SAMPLE. The multiplier's internal mantissa register captures at this edge.
  - SAMPLE: capture is allowed when !out_valid | out_ready.
    - If allowed: load out_Result = {mul_out_Sign, mul_out_Exponent, mul_out_Mantissa}, along with out_Overflow and out_Underflow, and set out_valid. Then, if count > 0, pop and go to APPLY (back-to-back); else go to IDLE.
    - If not allowed: stay in SAMPLE with operands held, so multiplier outputs remain stable.
- Output register: out_valid clears on out_valid & out_ready unless a SAMPLE capture occurs the same edge, in which case it stays 1 with new data.
- Same-edge push and pop: count unchanged. Pop is never attempted on an empty FIFO.
- Count width: log2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- No arithmetic is performed in this block; fields are sliced and concatenated only.

## Timing
- Reset values:
  - state IDLE, FIFO count 0, pointers 0
  - operand registers 0, so all mul_* outputs are 0
  - out_valid 0, out_Result 0x0000, out_Overflow 0, out_Underflow 0
  - in_ready 1 from the first cycle after reset
- Reset mid-operation discards FIFO contents, the in-flight pair, and any held result. No result appears afterwards.
- Latency: pair accepted at edge E0 → popped at E1 (APPLY) → SAMPLE at E2 → captured at E3. out_valid is high in the cycle after E3. That is 3 cycles when the FIFO is empty and the output register is free.
- Throughput: one result per 2 cycles sustained.
- Storage: at most FIFO_DEPTH + 2 pairs in flight (FIFO, operand registers, output register) while out_ready is held low.
- Ordering: results leave in acceptance order; none are dropped or duplicated.

## Test plan
- Single op: 0x3C00 × 0x3C00, out_ready=1 → out_Result=0x3C00 with out_valid high 3 cycles after acceptance; Overflow=0, Underflow=0.
- Back-to-back: 0x4000×0x4200 then 0x3C00×0x4500, pushed on consecutive cycles → 0x4600 then 0x4500, captured 2 cycles apart.
- Zero operand: 0x0000 × 0x4500 → out_Result=0x0000, no flags.
- Overflow: 0x7800 × 0x7800 → out_Overflow=1 captured with its result.
- Backpressure with FIFO_DEPTH=4: 7 pairs offered, out_ready=0 → exactly 6 accepted, then in_ready=0 and FSM held in SAMPLE. Raise out_ready → all 7 results in order, and in_ready returns to 1.
- Reset mid-burst: assert reset for 1 cycle while in SAMPLE with 3 pairs queued → next cycle out_valid=0, in_ready=1, no stale results emitted afterwards.
